// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - sync-word framed bit receiver with byte handshake; optional checksum via RX_CHECKSUM_EN
module rx_frame_ctrl #(
   parameter logic [7:0]  SYNC_WORD = 8'hA7,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       bit_i,
   input  logic       bit_valid,
   output logic       dec_en,
   output logic [7:0] byte_o,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       busy,
   output logic       frame_done,
   output logic       frame_err,
   output logic       ovf
);

`ifdef RX_CHECKSUM_EN
   typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_DONE} state_t;
`endif

   // last idle count value before the abort fires
   localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  sr;
   logic [2:0]  bit_cnt;
   logic [7:0]  remaining;
   logic [15:0] idle_cnt;
`ifdef RX_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   logic [7:0]  sr_next;
   logic        byte_last;
   logic        timeout_hit;
   logic        byte_done;
   logic        byte_accept;

   assign sr_next     = {sr[6:0], bit_i};
   assign byte_last   = bit_valid && (bit_cnt == 3'd7);
   assign timeout_hit = !bit_valid && (idle_cnt == IDLE_LAST);
   assign byte_done   = byte_last && (state == S_PAYLOAD);
   assign byte_accept = byte_valid && byte_ready;

   // frame state machine: sync hunt, length, payload, optional checksum, done
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_HUNT;
         sr         <= 8'd0;
         bit_cnt    <= 3'd0;
         remaining  <= 8'd0;
         idle_cnt   <= 16'd0;
`ifdef RX_CHECKSUM_EN
         csum       <= 8'd0;
`endif
         dec_en     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         idle_cnt   <= bit_valid ? 16'd0 : idle_cnt + 16'd1;
         case (state)
            S_HUNT: begin
               idle_cnt <= 16'd0;
               if (bit_valid) begin
                  sr <= sr_next;
                  if (sr_next == SYNC_WORD) begin
                     state   <= S_LEN;
                     bit_cnt <= 3'd0;
                     dec_en  <= 1'b1;
                     busy    <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state    <= S_HUNT;
               busy     <= 1'b0;
               sr       <= 8'd0;
               bit_cnt  <= 3'd0;
               idle_cnt <= 16'd0;
            end
            default: begin
               if (timeout_hit) begin
                  state     <= S_HUNT;
                  frame_err <= 1'b1;
                  dec_en    <= 1'b0;
                  busy      <= 1'b0;
                  sr        <= 8'd0;
                  bit_cnt   <= 3'd0;
               end else if (bit_valid) begin
                  sr      <= sr_next;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (byte_last) begin
                     if (state == S_LEN) begin
                        if (sr_next == 8'd0) begin
                           state     <= S_HUNT;
                           frame_err <= 1'b1;
                           dec_en    <= 1'b0;
                           busy      <= 1'b0;
                           sr        <= 8'd0;
                           bit_cnt   <= 3'd0;
                        end else begin
                           remaining <= sr_next;
                           state     <= S_PAYLOAD;
`ifdef RX_CHECKSUM_EN
                           csum      <= 8'd0;
`endif
                        end
                     end else if (state == S_PAYLOAD) begin
                        remaining <= remaining - 8'd1;
`ifdef RX_CHECKSUM_EN
                        // dropped bytes still count towards the checksum
                        csum      <= csum ^ sr_next;
                        if (remaining == 8'd1) begin
                           state <= S_CHK;
                        end
`else
                        if (remaining == 8'd1) begin
                           state      <= S_DONE;
                           dec_en     <= 1'b0;
                           frame_done <= 1'b1;
                        end
`endif
`ifdef RX_CHECKSUM_EN
                     end else if (state == S_CHK) begin
                        if (sr_next == csum) begin
                           state      <= S_DONE;
                           dec_en     <= 1'b0;
                           frame_done <= 1'b1;
                        end else begin
                           state     <= S_HUNT;
                           frame_err <= 1'b1;
                           dec_en    <= 1'b0;
                           busy      <= 1'b0;
                           sr        <= 8'd0;
                           bit_cnt   <= 3'd0;
                        end
`endif
                     end else begin
                        state  <= S_HUNT;
                        dec_en <= 1'b0;
                        busy   <= 1'b0;
                        sr     <= 8'd0;
                     end
                  end
               end
            end
         endcase
      end
   end

   // single-entry output buffer; a byte arriving while one is still pending is dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_o     <= 8'd0;
         byte_valid <= 1'b0;
         ovf        <= 1'b0;
      end else if (byte_done) begin
         if (!byte_valid || byte_accept) begin
            byte_o     <= sr_next;
            byte_valid <= 1'b1;
         end else begin
            ovf <= 1'b1;
         end
      end else if (byte_accept) begin
         byte_valid <= 1'b0;
      end
   end

endmodule
